// File: rtl/uart_rx_if.sv
// Serial-receive bundle: the raw line plus the parallel byte, its strobes
// and the busy flag. The receiver takes the master view; whatever consumes
// the bytes (and drives the line in a bench) takes the slave view.
interface uart_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output data,
        output valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The serial line is double-flopped into rx_s and every
// decision is taken on rx_s. A start edge seen in IDLE arms a half-bit wait,
// after which the start bit is re-checked (rejecting glitches), then eight
// data bits and the stop bit are sampled one bit period apart, near the
// middle of each bit. A good stop publishes the byte with a one-cycle valid
// strobe; a low stop raises a one-cycle frame_err and the receiver then
// waits for the line to go high before it will look for a new start.
//
// The FSM returns to IDLE right at the stop-bit sample point, i.e. mid-way
// through the stop bit, so a following start edge exactly one stop bit
// later is caught without any extra idle time on the line.
module uart_rx #(
    parameter int unsigned DIVIDER = 6,   // system clocks per bit, >= 4
    parameter int unsigned CNT_W   = 16   // 2**CNT_W must exceed DIVIDER
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    // Counter reload values: the counter counts down to zero and the line is
    // sampled in the cycle it reads zero, so a wait of N cycles loads N-1.
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIVIDER / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic             sync1_q;
    logic             sync2_q;
    logic             rx_s;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             frame_err_q;
    logic             busy_q;

    logic             cnt_done_s;

    assign rx_s       = sync2_q;
    assign cnt_done_s = (cnt_q == CNT_ZERO);

    // Two-flop synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= bus.rx;
            sync2_q <= sync1_q;
        end
    end

    // Receive FSM with bit timer, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a branch below raises them.
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        // t0: falling edge seen, wait half a bit.
                        state_q <= START;
                        cnt_q   <= HALF_LOAD;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                START: begin
                    if (cnt_done_s) begin
                        if (!rx_s) begin
                            // Start bit confirmed at its middle.
                            state_q <= DATA;
                            idx_q   <= 3'd0;
                            cnt_q   <= BIT_LOAD;
                            busy_q  <= 1'b1;
                        end else begin
                            // Line already back high: glitch, not a frame.
                            state_q <= IDLE;
                            cnt_q   <= CNT_ZERO;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                DATA: begin
                    if (cnt_done_s) begin
                        // LSB arrives first, so shift in from the top.
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt_q   <= BIT_LOAD;
                        if (idx_q == 3'd7) begin
                            state_q <= STOP;
                            idx_q   <= 3'd0;
                        end else begin
                            state_q <= DATA;
                            idx_q   <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                STOP: begin
                    if (cnt_done_s) begin
                        cnt_q <= CNT_ZERO;
                        if (rx_s) begin
                            // Good frame: publish and re-arm mid stop bit.
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            // Framing error: keep old data, wait for idle.
                            frame_err_q <= 1'b1;
                            state_q     <= WAIT_HIGH;
                            busy_q      <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end

                WAIT_HIGH: begin
                    // A break or stuck-low line must not look like a start.
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= WAIT_HIGH;
                        busy_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    cnt_q   <= CNT_ZERO;
                    idx_q   <= 3'd0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at DIVIDER=6. A table of frames (good bytes,
// a bad-stop frame, loopback bytes) is driven by a small bit-banging
// transmitter and checked against hand-computed results, followed by
// hand-written sequences for glitch rejection, back-to-back frames and a
// reset in the middle of a frame.
module tb_uart_rx;

    localparam int DIV     = 6;
    localparam int LATENCY = 60;  // pin start -> valid: 2 + 3 + 54 + 1

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    uart_rx_if bus ();

    uart_rx #(
        .DIVIDER (DIV),
        .CNT_W   (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Pulse monitor state (written only by the monitor process).
    int         vcnt = 0;
    int         fcnt = 0;
    int         both = 0;
    int         vq_cyc[$];
    logic [7:0] vq_data[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record strobes away from the active edge.
    always @(negedge clk) begin
        if (bus.valid) begin
            vcnt = vcnt + 1;
            vq_cyc.push_back(cyc);
            vq_data.push_back(bus.data);
        end
        if (bus.frame_err) fcnt = fcnt + 1;
        if (bus.valid && bus.frame_err) both = both + 1;
    end

    typedef struct {
        logic [7:0] byte_v;
        logic       stop_v;
        int         low_hold;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v,
                              input int low_hold, output int start_cyc);
        bus.rx    = 1'b0;
        start_cyc = cyc;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            tick(DIV);
        end
        bus.rx = stop_v;
        tick(DIV);
        if (!stop_v) tick(low_hold);
        bus.rx = 1'b1;
    endtask

    initial begin
        int sc;
        int sc2;
        int v0;
        int f0;
        int q0;

        tbl[0] = '{8'h55, 1'b1, 0,  1, 0, 8'h55};
        tbl[1] = '{8'hA3, 1'b1, 0,  1, 0, 8'hA3};
        tbl[2] = '{8'h00, 1'b1, 0,  1, 0, 8'h00};
        tbl[3] = '{8'hFF, 1'b1, 0,  1, 0, 8'hFF};
        tbl[4] = '{8'h81, 1'b0, 30, 0, 1, 8'hFF};  // bad stop: data kept
        tbl[5] = '{8'h42, 1'b1, 0,  1, 0, 8'h42};
        tbl[6] = '{8'h7E, 1'b1, 0,  1, 0, 8'h7E};

        bus.rx = 1'b1;
        rst    = 1'b1;
        tick(3);
        check("reset_data",  int'(bus.data),      8'h00);
        check("reset_valid", int'(bus.valid),     0);
        check("reset_ferr",  int'(bus.frame_err), 0);
        check("reset_busy",  int'(bus.busy),      0);
        rst = 1'b0;
        tick(5);

        // Two-cycle low glitch while idle.
        v0 = vcnt;
        f0 = fcnt;
        bus.rx = 1'b0;
        tick(2);
        bus.rx = 1'b1;
        tick(2);
        check("glitch_busy_seen", int'(bus.busy), 1);
        tick(2);
        check("glitch_busy_clear", int'(bus.busy), 0);
        tick(10);
        check("glitch_no_valid", vcnt - v0, 0);
        check("glitch_no_ferr",  fcnt - f0, 0);

        // Table of single frames with idle gaps.
        for (int i = 0; i < 7; i++) begin
            v0 = vcnt;
            f0 = fcnt;
            q0 = vq_cyc.size();
            send_frame(tbl[i].byte_v, tbl[i].stop_v, tbl[i].low_hold, sc);
            tick(12);
            check($sformatf("vec%0d_valid_cnt", i), vcnt - v0, tbl[i].exp_valid);
            check($sformatf("vec%0d_ferr_cnt", i),  fcnt - f0, tbl[i].exp_ferr);
            check($sformatf("vec%0d_data", i), int'(bus.data), int'(tbl[i].exp_data));
            check($sformatf("vec%0d_busy_idle", i), int'(bus.busy), 0);
            if (tbl[i].exp_valid == 1 && vq_cyc.size() > q0)
                check($sformatf("vec%0d_latency", i), vq_cyc[q0] - sc, LATENCY);
        end

        // Back-to-back frames with a one-bit stop.
        v0 = vcnt;
        q0 = vq_cyc.size();
        send_frame(8'hA3, 1'b1, 0, sc);
        send_frame(8'h0F, 1'b1, 0, sc2);
        tick(12);
        check("b2b_valid_cnt", vcnt - v0, 2);
        if (vq_cyc.size() >= q0 + 2) begin
            check("b2b_first_data",  int'(vq_data[q0]),     8'hA3);
            check("b2b_second_data", int'(vq_data[q0 + 1]), 8'h0F);
            check("b2b_spacing", vq_cyc[q0 + 1] - vq_cyc[q0], 60);
            check("b2b_latency", vq_cyc[q0] - sc, LATENCY);
        end

        // Reset during data bit 4 of 0xFF, then a clean 0x3C.
        v0 = vcnt;
        f0 = fcnt;
        bus.rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 4; i++) begin
            bus.rx = 1'b1;
            tick(DIV);
        end
        bus.rx = 1'b1;
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_data", int'(bus.data), 8'h00);
        check("midrst_busy", int'(bus.busy), 0);
        tick(3 + 3 * DIV + DIV);
        tick(12);
        check("midrst_no_valid", vcnt - v0, 0);
        check("midrst_no_ferr",  fcnt - f0, 0);
        send_frame(8'h3C, 1'b1, 0, sc);
        tick(12);
        check("after_rst_valid_cnt", vcnt - v0, 1);
        check("after_rst_data", int'(bus.data), 8'h3C);

        check("valid_ferr_overlap", both, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
